// File: rtl/deser_train_ctrl.sv
// deser_train_ctrl: per-channel bitslip training sequencer for the LVDS deserializer.
// Optional DESER_TRAIN_MONITOR_EN: keep watching lock in DONE and retrain when it is lost.
module deser_train_ctrl #(
  parameter int DESER_WIDTH = 8,
  parameter int CHANNEL_NUM = 4,
  parameter logic [DESER_WIDTH-1:0] TRAIN_PATTERN = 8'hF0,
  parameter int MATCH_NUM = 16,
  parameter int SLIP_WAIT = 4,
  localparam int CW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               i_start,
  input  logic [DESER_WIDTH*CHANNEL_NUM-1:0] iv_data,
  output logic [CHANNEL_NUM-1:0]             ov_bitslip,
  output logic [CHANNEL_NUM-1:0]             ov_ch_lock,
  output logic [CW-1:0]                      ov_cur_ch,
  output logic                               o_busy,
  output logic                               o_train_done,
  output logic                               o_train_fail
);

  localparam int MW = $clog2(MATCH_NUM + 1);
  localparam int SW = (DESER_WIDTH > 2) ? $clog2(DESER_WIDTH) : 1;
  localparam int WW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
  localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_NUM - 1);
  localparam logic [SW-1:0] SLIP_LAST  = SW'(DESER_WIDTH - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(SLIP_WAIT - 1);
  localparam logic [CW-1:0] CH_LAST    = CW'(CHANNEL_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SLIP,
    S_WAIT,
    S_NEXT,
    S_DONE,
    S_FAIL
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          ch_q;
  logic [SW-1:0]          slip_q;
  logic [MW-1:0]          match_q;
  logic [WW-1:0]          wait_q;
  logic [CHANNEL_NUM-1:0] bitslip_q;
  logic [CHANNEL_NUM-1:0] lock_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   fail_q;

  logic [CHANNEL_NUM-1:0] hit_vec;
  logic [CHANNEL_NUM-1:0] drop;
  logic                   hit;

  always_comb begin
    hit_vec = '0;
    for (int n = 0; n < CHANNEL_NUM; n++) begin
      hit_vec[n] = (iv_data[n*DESER_WIDTH +: DESER_WIDTH] == TRAIN_PATTERN);
    end
  end

  assign hit = hit_vec[ch_q];

`ifdef DESER_TRAIN_MONITOR_EN
  logic [MW-1:0] miss_q [CHANNEL_NUM];

  // Consecutive-miss counters only run while parked in DONE.
  always_ff @(posedge clk) begin
    for (int n = 0; n < CHANNEL_NUM; n++) begin
      if (reset || state_q != S_DONE || hit_vec[n]) begin
        miss_q[n] <= '0;
      end else if (miss_q[n] != MATCH_LAST) begin
        miss_q[n] <= miss_q[n] + 1'b1;
      end
    end
  end

  always_comb begin
    drop = '0;
    for (int n = 0; n < CHANNEL_NUM; n++) begin
      drop[n] = (state_q == S_DONE) && !hit_vec[n] &&
                (miss_q[n] == MATCH_LAST);
    end
  end
`else
  assign drop = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      slip_q    <= '0;
      match_q   <= '0;
      wait_q    <= '0;
      bitslip_q <= '0;
      lock_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      bitslip_q <= '0;
      unique case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (i_start) begin
            state_q <= S_CHECK;
            ch_q    <= '0;
            slip_q  <= '0;
            match_q <= '0;
            wait_q  <= '0;
            lock_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
          end else if (|drop) begin
            state_q <= S_CHECK;
            ch_q    <= '0;
            slip_q  <= '0;
            match_q <= '0;
            wait_q  <= '0;
            lock_q  <= lock_q & ~drop;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_CHECK: begin
          if (hit) begin
            match_q <= match_q + 1'b1;
            if (match_q == MATCH_LAST) begin
              lock_q[ch_q] <= 1'b1;
              state_q      <= S_NEXT;
            end
          end else begin
            match_q <= '0;
            if (slip_q != SLIP_LAST) begin
              bitslip_q[ch_q] <= 1'b1;
              state_q         <= S_SLIP;
            end else begin
              lock_q[ch_q] <= 1'b0;
              state_q      <= S_NEXT;
            end
          end
        end
        S_SLIP: begin
          slip_q  <= slip_q + 1'b1;
          wait_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            match_q <= '0;
            state_q <= S_CHECK;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_NEXT: begin
          slip_q  <= '0;
          match_q <= '0;
          if (ch_q == CH_LAST) begin
            busy_q <= 1'b0;
            if (&lock_q) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              fail_q  <= 1'b1;
              state_q <= S_FAIL;
            end
          end else begin
            ch_q    <= ch_q + 1'b1;
            state_q <= S_CHECK;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ov_bitslip   = bitslip_q;
  assign ov_ch_lock   = lock_q;
  assign ov_cur_ch    = ch_q;
  assign o_busy       = busy_q;
  assign o_train_done = done_q;
  assign o_train_fail = fail_q;

endmodule

// File: tb/tb_deser_train_ctrl.sv
// Bench for deser_train_ctrl: emulated skewed deserializer channels with
// random slip latency, checked against a training-time/outcome model.
`timescale 1ns/1ps
module tb_deser_train_ctrl;
  localparam int W = 8;
  localparam int N = 4;
  localparam int MN = 16;
  localparam int SWT = 4;
  localparam logic [7:0] PAT = 8'hF0;

  logic clk = 1'b0;
  logic reset;
  logic i_start;
  logic [W*N-1:0] iv_data;
  logic [N-1:0] ov_bitslip;
  logic [N-1:0] ov_ch_lock;
  logic [1:0] ov_cur_ch;
  logic o_busy;
  logic o_train_done;
  logic o_train_fail;

  always #5 clk = ~clk;

  deser_train_ctrl #(
    .DESER_WIDTH(W), .CHANNEL_NUM(N), .TRAIN_PATTERN(PAT),
    .MATCH_NUM(MN), .SLIP_WAIT(SWT)
  ) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .iv_data(iv_data),
    .ov_bitslip(ov_bitslip), .ov_ch_lock(ov_ch_lock),
    .ov_cur_ch(ov_cur_ch), .o_busy(o_busy),
    .o_train_done(o_train_done), .o_train_fail(o_train_fail)
  );

  int n_chk = 0;
  int n_fail = 0;

  int rot [N];
  bit stuck [N];
  logic [7:0] stuck_val [N];
  bit corrupt [N];
  int applied [N];
  int pend [N];
  int pulses [N];
  int last_pulse [N];
  int space_err;
  int multi_err;
  int cyc;

  function automatic logic [7:0] rotl(logic [7:0] v, int k);
    int s;
    s = ((k % 8) + 8) % 8;
    return (v << s) | (v >> ((8 - s) % 8));
  endfunction

  task automatic drive_data();
    for (int n = 0; n < N; n++) begin
      if (corrupt[n]) iv_data[n*W +: W] = 8'h00;
      else if (stuck[n]) iv_data[n*W +: W] = stuck_val[n];
      else iv_data[n*W +: W] = rotl(PAT, rot[n] - applied[n]);
    end
  endtask

  task automatic cfg(input int n, input int r, input bit st,
                     input logic [7:0] v);
    rot[n] = r;
    stuck[n] = st;
    stuck_val[n] = v;
    corrupt[n] = 1'b0;
    applied[n] = 0;
    pend[n] = 0;
    drive_data();
  endtask

  task automatic cfg_aligned();
    for (int n = 0; n < N; n++) cfg(n, 0, 1'b0, 8'h00);
  endtask

  task automatic clr_stats();
    for (int n = 0; n < N; n++) begin
      pulses[n] = 0;
      last_pulse[n] = -1;
    end
    space_err = 0;
    multi_err = 0;
  endtask

  // Expected training length: per channel, each slip costs slip+wait+check,
  // a lock needs MN matches, a failed channel tries every rotation once.
  function automatic int exp_cycles();
    int t;
    t = 0;
    for (int n = 0; n < N; n++) begin
      if (stuck[n]) t += (SWT + 2) * (W - 1) + 1 + 1;
      else t += (SWT + 2) * rot[n] + MN + 1;
    end
    return t;
  endfunction

  function automatic logic [N-1:0] exp_lock();
    logic [N-1:0] l;
    for (int n = 0; n < N; n++) l[n] = !stuck[n];
    return l;
  endfunction

  // Deserializer emulation: each bitslip rotates the word after 1..SWT cycles.
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if ($countones(ov_bitslip) > 1) multi_err++;
      for (int n = 0; n < N; n++) begin
        if (pend[n] > 0) begin
          pend[n]--;
          if (pend[n] == 0) applied[n]++;
        end
        if (ov_bitslip[n] === 1'b1) begin
          pulses[n]++;
          if (last_pulse[n] >= 0 && cyc - last_pulse[n] != SWT + 2)
            space_err++;
          last_pulse[n] = cyc;
          pend[n] = $urandom_range(1, SWT);
        end
      end
      drive_data();
    end
  end

  task automatic run_train(output int cycles, output bit tmo);
    clr_stats();
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    cycles = 0;
    tmo = 1'b0;
    while (!(o_train_done || o_train_fail) && !tmo) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles > 3000) tmo = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({ov_bitslip, ov_ch_lock, ov_cur_ch, o_busy, o_train_done,
         o_train_fail} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %0h required 0",
               {ov_bitslip, ov_ch_lock, ov_cur_ch, o_busy, o_train_done,
                o_train_fail});
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (o_busy !== 1'b0 || ov_bitslip !== '0) begin
      n_fail++;
      $display("FAIL idle_no_start: busy %b slip %b required 0 0",
               o_busy, ov_bitslip);
    end
  endtask

  task automatic test_aligned();
    int c;
    bit t;
    cfg_aligned();
    run_train(c, t);
    n_chk++;
    if (t !== 1'b0 || c !== 68) begin
      n_fail++;
      $display("FAIL aligned_cycles: got %0d (tmo %b) required 68", c, t);
    end
    n_chk++;
    if ({o_train_done, o_train_fail, o_busy, ov_ch_lock} !== 7'b100_1111) begin
      n_fail++;
      $display("FAIL aligned_flags: got %b required 1001111",
               {o_train_done, o_train_fail, o_busy, ov_ch_lock});
    end
    n_chk++;
    if (pulses[0] + pulses[1] + pulses[2] + pulses[3] !== 0) begin
      n_fail++;
      $display("FAIL aligned_slips: got %0d required 0",
               pulses[0] + pulses[1] + pulses[2] + pulses[3]);
    end
    n_chk++;
    if (ov_cur_ch !== 2'd3) begin
      n_fail++;
      $display("FAIL aligned_cur_ch: got %0d required 3", ov_cur_ch);
    end
  endtask

  task automatic test_ch2_rot3();
    int c;
    bit t;
    cfg_aligned();
    cfg(2, 3, 1'b0, 8'h00);
    run_train(c, t);
    n_chk++;
    if (pulses[2] !== 3 || pulses[0] + pulses[1] + pulses[3] !== 0) begin
      n_fail++;
      $display("FAIL rot3_pulses: got ch2 %0d others %0d required 3 0",
               pulses[2], pulses[0] + pulses[1] + pulses[3]);
    end
    n_chk++;
    if (space_err !== 0 || multi_err !== 0) begin
      n_fail++;
      $display("FAIL rot3_spacing: got space %0d multi %0d required 0 0",
               space_err, multi_err);
    end
    n_chk++;
    if (t !== 1'b0 || c !== 86 || o_train_done !== 1'b1 ||
        ov_ch_lock !== 4'hF) begin
      n_fail++;
      $display("FAIL rot3_result: got cyc %0d done %b lock %h required 86 1 f",
               c, o_train_done, ov_ch_lock);
    end
  endtask

  task automatic test_ch1_stuck();
    int c;
    bit t;
    cfg_aligned();
    cfg(1, 0, 1'b1, 8'h00);
    run_train(c, t);
    n_chk++;
    if (pulses[1] !== 7) begin
      n_fail++;
      $display("FAIL stuck_pulses: got %0d required 7", pulses[1]);
    end
    n_chk++;
    if ({o_train_fail, o_train_done, ov_ch_lock} !== 6'b10_1101) begin
      n_fail++;
      $display("FAIL stuck_flags: got %b required 101101",
               {o_train_fail, o_train_done, ov_ch_lock});
    end
    n_chk++;
    if (t !== 1'b0 || c !== 95) begin
      n_fail++;
      $display("FAIL stuck_cycles: got %0d required 95", c);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    int c;
    bit t;
    cfg_aligned();
    cfg(1, 2, 1'b0, 8'h00);
    clr_stats();
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    k = 0;
    while (pulses[1] == 0 && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_chk++;
    if (k >= 500 || ov_cur_ch !== 2'd1 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_reach_wait: got wait %0d ch %0d busy %b required <500 1 1",
               k, ov_cur_ch, o_busy);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if ({ov_bitslip, ov_ch_lock, ov_cur_ch, o_busy, o_train_done,
         o_train_fail} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %0h required 0",
               {ov_bitslip, ov_ch_lock, ov_cur_ch, o_busy, o_train_done,
                o_train_fail});
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (o_busy !== 1'b0 || ov_bitslip !== '0) begin
      n_fail++;
      $display("FAIL midreset_idle: busy %b slip %b required 0 0",
               o_busy, ov_bitslip);
    end
    cfg_aligned();
    run_train(c, t);
    n_chk++;
    if (t !== 1'b0 || c !== 68 || ov_ch_lock !== 4'hF ||
        o_train_done !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_retrain: got cyc %0d lock %h done %b required 68 f 1",
               c, ov_ch_lock, o_train_done);
    end
  endtask

  task automatic test_start_busy();
    int c;
    bit t;
    cfg_aligned();
    clr_stats();
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    c = 0;
    t = 1'b0;
    while (!o_train_done && !t) begin
      i_start = (c == 20);
      @(posedge clk);
      #1;
      c++;
      if (c > 3000) t = 1'b1;
    end
    i_start = 1'b0;
    n_chk++;
    if (t !== 1'b0 || c !== 68) begin
      n_fail++;
      $display("FAIL busy_start_ignored: got cyc %0d required 68", c);
    end
    cfg_aligned();
    cfg(0, 0, 1'b1, 8'hAA);
    run_train(c, t);
    n_chk++;
    if (o_train_fail !== 1'b1 || ov_ch_lock !== 4'b1110) begin
      n_fail++;
      $display("FAIL ch0_fail: got fail %b lock %b required 1 1110",
               o_train_fail, ov_ch_lock);
    end
    cfg_aligned();
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    n_chk++;
    if ({ov_ch_lock, o_train_fail, o_busy, ov_cur_ch} !== 8'b0000_0_1_00) begin
      n_fail++;
      $display("FAIL restart_from_fail: got %b required 00000100",
               {ov_ch_lock, o_train_fail, o_busy, ov_cur_ch});
    end
    c = 0;
    t = 1'b0;
    while (!o_train_done && !t) begin
      @(posedge clk);
      #1;
      c++;
      if (c > 3000) t = 1'b1;
    end
    n_chk++;
    if (t !== 1'b0 || c !== 68 || ov_ch_lock !== 4'hF) begin
      n_fail++;
      $display("FAIL retrain_after_fail: got cyc %0d lock %h required 68 f",
               c, ov_ch_lock);
    end
  endtask

  task automatic test_done_hold();
    int c;
    bit t;
    cfg_aligned();
    run_train(c, t);
    corrupt[3] = 1'b1;
    drive_data();
`ifdef DESER_TRAIN_MONITOR_EN
    repeat (15) @(posedge clk);
    #1;
    n_chk++;
    if (o_train_done !== 1'b1 || ov_ch_lock !== 4'hF) begin
      n_fail++;
      $display("FAIL monitor_early_drop: got done %b lock %h required 1 f",
               o_train_done, ov_ch_lock);
    end
    @(posedge clk);
    #1;
    corrupt[3] = 1'b0;
    drive_data();
    n_chk++;
    if ({ov_ch_lock[3], o_train_done, o_busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL monitor_drop: got lock3 done busy %b required 001",
               {ov_ch_lock[3], o_train_done, o_busy});
    end
    c = 0;
    t = 1'b0;
    while (!o_train_done && !t) begin
      @(posedge clk);
      #1;
      c++;
      if (c > 3000) t = 1'b1;
    end
    n_chk++;
    if (t !== 1'b0 || c !== 68 || ov_ch_lock !== 4'hF) begin
      n_fail++;
      $display("FAIL monitor_retrain: got cyc %0d lock %h required 68 f",
               c, ov_ch_lock);
    end
`else
    repeat (24) @(posedge clk);
    #1;
    corrupt[3] = 1'b0;
    drive_data();
    n_chk++;
    if ({o_train_done, o_busy, ov_ch_lock} !== 6'b10_1111) begin
      n_fail++;
      $display("FAIL done_sticky: got %b required 101111",
               {o_train_done, o_busy, ov_ch_lock});
    end
`endif
  endtask

  task automatic test_random();
    int c;
    bit t;
    logic [7:0] bad [5];
    bad[0] = 8'h00;
    bad[1] = 8'hFF;
    bad[2] = 8'hAA;
    bad[3] = 8'h55;
    bad[4] = 8'h81;
    for (int it = 0; it < 8; it++) begin
      for (int n = 0; n < N; n++) begin
        if ($urandom_range(0, 4) == 0)
          cfg(n, 0, 1'b1, bad[$urandom_range(0, 4)]);
        else
          cfg(n, $urandom_range(0, 7), 1'b0, 8'h00);
      end
      run_train(c, t);
      n_chk++;
      if (t !== 1'b0 || c !== exp_cycles()) begin
        n_fail++;
        $display("FAIL rand%0d_cycles: got %0d required %0d", it, c,
                 exp_cycles());
      end
      n_chk++;
      if (ov_ch_lock !== exp_lock() ||
          o_train_done !== (exp_lock() == 4'hF) ||
          o_train_fail !== (exp_lock() != 4'hF)) begin
        n_fail++;
        $display("FAIL rand%0d_result: got lock %b done %b fail %b required lock %b",
                 it, ov_ch_lock, o_train_done, o_train_fail, exp_lock());
      end
      for (int n = 0; n < N; n++) begin
        n_chk++;
        if (pulses[n] !== (stuck[n] ? W - 1 : rot[n])) begin
          n_fail++;
          $display("FAIL rand%0d_pulses_ch%0d: got %0d required %0d", it, n,
                   pulses[n], stuck[n] ? W - 1 : rot[n]);
        end
      end
      n_chk++;
      if (space_err !== 0 || multi_err !== 0) begin
        n_fail++;
        $display("FAIL rand%0d_spacing: got space %0d multi %0d required 0 0",
                 it, space_err, multi_err);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    i_start = 1'b0;
    iv_data = '0;
    clr_stats();
    cfg_aligned();
    test_reset();
    test_aligned();
    test_ch2_rot3();
    test_ch1_stuck();
    test_reset_mid();
    test_start_busy();
    test_done_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
